rtp_rx_seq_checker: RTL and testbench

// Receive-side counterpart of the RTP transmit engine's sequence numbering. Monitors an RTP/RFC4175 packet

---
 rtl/rtp_rx_seq_checker.sv | 165 ++++++++++++++++
 tb/tb_rtp_rx_seq_checker.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rtp_rx_seq_checker.sv
// RTP/RFC4175 receive sequence checker.
// Passes an AXI-Stream through unmodified, parses the 4-word RTP/RFC4175 header,
// rebuilds the 32-bit extended sequence number and tracks continuity counters
// behind a small up_* register interface.
module rtp_rx_seq_checker #(
    parameter logic [31:0] VERSION = 32'd1
) (
    input  logic        up_clk,
    input  logic        up_rstn,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tlast,
    input  logic        up_wreq,
    input  logic [13:0] up_waddr,
    input  logic [31:0] up_wdata,
    output logic        up_wack,
    input  logic        up_rreq,
    input  logic [13:0] up_raddr,
    output logic [31:0] up_rdata,
    output logic        up_rack
);

    typedef enum logic [2:0] {W0, W1, W2, W3, PAY} state_t;

    state_t      state;
    logic [15:0] seq_q;
    logic        header_ok;
    logic        pkt_en;
    logic        enable;
    logic        synced;
    logic [31:0] last_seq, expected, pkt_cnt, lost_cnt, ooo_cnt, hdr_err_cnt;

    assign s_axis_tready = m_axis_tready;
    assign m_axis_tvalid = s_axis_tvalid;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tlast  = s_axis_tlast;

    logic        beat, wr_ctrl, clr, dis, en_now;
    logic [31:0] ext, d;
    logic [32:0] lost_sum;
    logic        unused_ok;

    assign beat     = s_axis_tvalid & m_axis_tready;
    assign wr_ctrl  = up_wreq && (up_waddr == 14'h1);
    assign clr      = wr_ctrl && up_wdata[1];
    assign dis      = wr_ctrl && !up_wdata[0] && enable;
    // On the W0 beat pkt_en is being latched, so the live enable applies.
    assign en_now   = (state == W0) ? enable : pkt_en;
    assign ext      = {s_axis_tdata[31:16], seq_q};
    assign d        = ext - expected;
    assign lost_sum = {1'b0, lost_cnt} + {1'b0, d};
    assign unused_ok = &{1'b0, up_wdata[31:2]};

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Header parser FSM: walks the four header words, then payload until tlast.
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            state     <= W0;
            seq_q     <= '0;
            header_ok <= 1'b0;
            pkt_en    <= 1'b0;
        end else if (beat) begin
            case (state)
                W0: begin
                    seq_q     <= s_axis_tdata[15:0];
                    header_ok <= (s_axis_tdata[31:30] == 2'd2) && !s_axis_tdata[28] &&
                                 (s_axis_tdata[27:24] == 4'd0);
                    pkt_en    <= enable;
                    state     <= s_axis_tlast ? W0 : W1;
                end
                W1:      state <= s_axis_tlast ? W0 : W2;
                W2:      state <= s_axis_tlast ? W0 : W3;
                W3:      state <= s_axis_tlast ? W0 : PAY;
                default: state <= s_axis_tlast ? W0 : PAY;
            endcase
        end
    end

    // Counters and sequence tracking; a clear on the same cycle overrides any update.
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            synced      <= 1'b0;
            last_seq    <= '0;
            expected    <= '0;
            pkt_cnt     <= '0;
            lost_cnt    <= '0;
            ooo_cnt     <= '0;
            hdr_err_cnt <= '0;
        end else if (clr) begin
            synced      <= 1'b0;
            last_seq    <= '0;
            expected    <= '0;
            pkt_cnt     <= '0;
            lost_cnt    <= '0;
            ooo_cnt     <= '0;
            hdr_err_cnt <= '0;
        end else begin
            if (beat && state != PAY) begin
                if (s_axis_tlast) begin
                    // Runt: packet ended inside the header (including on W3).
                    if (en_now) hdr_err_cnt <= sat_inc(hdr_err_cnt);
                end else if (state == W3 && pkt_en) begin
                    if (!header_ok) begin
                        hdr_err_cnt <= sat_inc(hdr_err_cnt);
                    end else begin
                        pkt_cnt  <= sat_inc(pkt_cnt);
                        last_seq <= ext;
                        if (!synced) begin
                            synced   <= 1'b1;
                            expected <= ext + 32'd1;
                        end else if (d == 32'd0) begin
                            expected <= ext + 32'd1;
                        end else if (!d[31]) begin
                            lost_cnt <= lost_sum[32] ? 32'hFFFF_FFFF : lost_sum[31:0];
                            expected <= ext + 32'd1;
                        end else begin
                            ooo_cnt <= sat_inc(ooo_cnt);
                        end
                    end
                end
            end
            // Disabling the checker drops sync so the next stream resyncs cleanly.
            if (dis) synced <= 1'b0;
        end
    end

    // Register interface: one-cycle write/read acks, registered read data.
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            enable   <= 1'b0;
            up_wack  <= 1'b0;
            up_rack  <= 1'b0;
            up_rdata <= '0;
        end else begin
            up_wack <= up_wreq;
            up_rack <= up_rreq;
            if (wr_ctrl) enable <= up_wdata[0];
            if (!up_rreq || up_raddr[13:4] != 10'd0) begin
                up_rdata <= '0;
            end else begin
                case (up_raddr[3:0])
                    4'h0:    up_rdata <= VERSION;
                    4'h1:    up_rdata <= {31'd0, enable};
                    4'h2:    up_rdata <= last_seq;
                    4'h3:    up_rdata <= expected;
                    4'h4:    up_rdata <= pkt_cnt;
                    4'h5:    up_rdata <= lost_cnt;
                    4'h6:    up_rdata <= ooo_cnt;
                    4'h7:    up_rdata <= hdr_err_cnt;
                    4'h8:    up_rdata <= {31'd0, synced};
                    default: up_rdata <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rtp_rx_seq_checker.sv
// Scoreboard bench for rtp_rx_seq_checker: register reads and stream beats are
// queued at issue time and compared by an independent monitor.
module tb_rtp_rx_seq_checker;

    logic        up_clk = 1'b0;
    logic        up_rstn = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tlast = 1'b0;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        up_wreq = 1'b0;
    logic [13:0] up_waddr = '0;
    logic [31:0] up_wdata = '0;
    logic        up_wack;
    logic        up_rreq = 1'b0;
    logic [13:0] up_raddr = '0;
    logic [31:0] up_rdata;
    logic        up_rack;

    rtp_rx_seq_checker dut (
        .up_clk(up_clk), .up_rstn(up_rstn),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
        .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack)
    );

    always #5 up_clk = ~up_clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic        bp = 1'b0;
    logic [31:0] rd_q[$];
    string       rd_name_q[$];
    logic [32:0] beat_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Backpressure generator: ready only changes just after a rising edge.
    always @(posedge up_clk) begin
        #1;
        m_axis_tready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // Monitor: pops expected read data on up_rack, expected beats on m_axis handshakes.
    always @(negedge up_clk) begin
        if (up_rstn && up_rack) begin
            if (rd_q.size() == 0) begin
                chk("unexpected_rack", 32'd1, 32'd0);
            end else begin
                chk(rd_name_q.pop_front(), up_rdata, rd_q.pop_front());
            end
        end
        if (up_rstn && m_axis_tvalid && m_axis_tready) begin
            if (beat_q.size() == 0) begin
                chk("unexpected_beat", 32'd1, 32'd0);
            end else begin
                chk("m_axis_beat", {m_axis_tlast, m_axis_tdata}, beat_q.pop_front());
            end
        end
    end

    task automatic beat(input logic [31:0] data, input logic last);
        bit got = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = data;
        s_axis_tlast  = last;
        beat_q.push_back({last, data});
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge up_clk);
            if (m_axis_tready) got = 1;
            @(posedge up_clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        if (!got) chk("beat_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] w0(input logic [1:0] v, input logic [15:0] seq);
        return {v, 1'b0, 1'b0, 4'h0, 1'b0, 7'd96, seq};
    endfunction

    task automatic send_hdr(input logic [31:0] ext, input logic [1:0] v);
        beat(w0(v, ext[15:0]), 1'b0);
        beat(32'h1234_0000 + ext, 1'b0);
        beat(32'hCAFE_F00D, 1'b0);
        beat({ext[31:16], 16'd32}, 1'b0);
    endtask

    task automatic send_pay(input int n);
        for (int i = 0; i < n; i++) beat(32'hA000_0000 + i, i == n - 1);
    endtask

    task automatic send_pkt(input logic [31:0] ext);
        send_hdr(ext, 2'd2);
        send_pay(8);
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] v);
        up_wreq = 1'b1; up_waddr = a; up_wdata = v;
        @(posedge up_clk); #1;
        up_wreq = 1'b0;
        chk("wack", {31'd0, up_wack}, 32'd1);
    endtask

    task automatic rd(input logic [13:0] a, input logic [31:0] exp, input string name);
        rd_q.push_back(exp);
        rd_name_q.push_back(name);
        up_rreq = 1'b1; up_raddr = a;
        @(posedge up_clk); #1;
        up_rreq = 1'b0;
        @(posedge up_clk); #1;
    endtask

    task automatic rd_all(input logic [31:0] last, input logic [31:0] exp, input logic [31:0] pkt,
                          input logic [31:0] lost, input logic [31:0] ooo, input logic [31:0] hdr,
                          input logic [31:0] syn, input string tag);
        rd(14'h2, last, {tag, "_last_seq"});
        rd(14'h3, exp,  {tag, "_expected"});
        rd(14'h4, pkt,  {tag, "_pkt_cnt"});
        rd(14'h5, lost, {tag, "_lost_cnt"});
        rd(14'h6, ooo,  {tag, "_ooo_cnt"});
        rd(14'h7, hdr,  {tag, "_hdr_err"});
        rd(14'h8, syn,  {tag, "_synced"});
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge up_clk);
        #1;
        chk("rst_rack", {31'd0, up_rack}, 32'd0);
        chk("rst_wack", {31'd0, up_wack}, 32'd0);
        chk("rst_rdata", up_rdata, 32'd0);
        up_rstn = 1'b1;
        @(posedge up_clk); #1;
        rd_all(0, 0, 0, 0, 0, 0, 0, "rst");
        rd(14'h1, 32'd0, "rst_ctrl");

        // 1: in-order stream across the 16-bit wrap of the RTP seq
        wr(14'h1, 32'd1);
        rd(14'h1, 32'd1, "ctrl_enable");
        send_pkt(32'h0001_FFFE);
        send_pkt(32'h0001_FFFF);
        send_pkt(32'h0002_0000);
        send_pkt(32'h0002_0001);
        rd_all(32'h0002_0001, 32'h0002_0002, 4, 0, 0, 0, 1, "t1");

        // 2: gap then late packet
        wr(14'h1, 32'd3);
        send_pkt(32'h0000_000F);
        rd(14'h3, 32'h10, "t2_exp_sync");
        send_pkt(32'h0000_0015);
        rd(14'h5, 32'd5, "t2_lost");
        rd(14'h3, 32'h16, "t2_exp_gap");
        send_pkt(32'h0000_0012);
        rd_all(32'h12, 32'h16, 3, 5, 1, 0, 1, "t2");

        // 3: 32-bit wrap is in order; lost counter saturates
        wr(14'h1, 32'd3);
        send_pkt(32'hFFFF_FFFF);
        send_pkt(32'h0000_0000);
        rd(14'h5, 32'd0, "t3_wrap_lost");
        rd(14'h3, 32'h1, "t3_wrap_exp");
        send_pkt(32'h8000_0000);
        send_pkt(32'hFFFF_FFF2);
        rd(14'h5, 32'hFFFF_FFF0, "t3_lost_pre");
        send_pkt(32'h0000_00F3);
        rd(14'h5, 32'hFFFF_FFFF, "t3_lost_sat");
        rd(14'h3, 32'h0000_00F4, "t3_exp_sat");

        // 4: bad version and a runt under backpressure
        wr(14'h1, 32'd3);
        bp = 1'b1;
        send_hdr(32'h0000_0040, 2'd1);
        send_pay(5);
        beat(w0(2'd2, 16'h0041), 1'b0);
        beat(32'h1111_2222, 1'b1);
        send_pkt(32'h0000_0050);
        bp = 1'b0;
        rd_all(32'h50, 32'h51, 1, 0, 0, 2, 1, "t4");

        // 5: clear coinciding with the W3 beat wins over the sequence update
        wr(14'h1, 32'd3);
        send_pkt(32'h0000_0100);
        beat(w0(2'd2, 16'h0105), 1'b0);
        beat(32'h0, 1'b0);
        beat(32'h0, 1'b0);
        s_axis_tvalid = 1'b1; s_axis_tdata = {16'h0000, 16'd32}; s_axis_tlast = 1'b0;
        beat_q.push_back({1'b0, 16'h0000, 16'd32});
        up_wreq = 1'b1; up_waddr = 14'h1; up_wdata = 32'd3;
        @(posedge up_clk); #1;
        s_axis_tvalid = 1'b0; up_wreq = 1'b0;
        send_pay(4);
        rd_all(0, 0, 0, 0, 0, 0, 0, "t5_clr");
        send_pkt(32'h0000_0200);
        rd_all(32'h200, 32'h201, 1, 0, 0, 0, 1, "t5_resync");

        // 6: version, unmapped reads, then async reset mid-payload
        rd(14'h0, 32'd1, "version");
        rd(14'h9, 32'd0, "unmapped_9");
        rd(14'h10, 32'd0, "unmapped_10");
        wr(14'h10, 32'hFFFF_FFFF);
        rd(14'h1, 32'd1, "ctrl_after_bad_wr");
        send_hdr(32'h0000_0300, 2'd2);
        beat(32'h5, 1'b0);
        beat(32'h6, 1'b0);
        up_rreq = 1'b1; up_raddr = 14'h0;
        @(posedge up_clk); #1;
        up_rreq = 1'b0;
        chk("pre_rst_rack", {31'd0, up_rack}, 32'd1);
        chk("pre_rst_rdata", up_rdata, 32'd1);
        #2 up_rstn = 1'b0;
        #1;
        chk("async_rst_rack", {31'd0, up_rack}, 32'd0);
        chk("async_rst_rdata", up_rdata, 32'd0);
        chk("async_rst_wack", {31'd0, up_wack}, 32'd0);
        @(posedge up_clk); #1;
        chk("rd_queue_empty", rd_q.size(), 32'd0);
        chk("beat_queue_empty", beat_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
